// File: rtl/gate_tt_sequencer.sv
// Clocked truth-table sweeper for a 2-input combinational gate: drives X1/X2
// through 00..11, samples Z at the end of each hold window and scores it.
module gate_tt_sequencer #(
  parameter int         HOLD_CYCLES = 50,
  parameter logic [3:0] EXP_TT      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       Z,
  output logic       X1,
  output logic       X2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx,
  output logic       sample_valid,
  output logic       sample_z
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic [3:0]    mask_next;
  logic [2:0]    count_next;
  logic [1:0]    idx_next;

  // Score of the vector currently held, folded into the running results.
  always_comb begin
    mismatch   = (Z != EXP_TT[vec_idx]);
    mask_next  = err_mask;
    count_next = err_count;
    idx_next   = vec_idx + 2'd1;
    if (mismatch) begin
      mask_next  = err_mask | (4'b0001 << vec_idx);
      count_next = err_count + 3'd1;
    end else begin
      mask_next  = err_mask;
      count_next = err_count;
    end
  end

  // Sweep FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      X1           <= 1'b0;
      X2           <= 1'b0;
      vec_idx      <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_mask     <= 4'd0;
      err_count    <= 3'd0;
      sample_valid <= 1'b0;
      sample_z     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            X1        <= 1'b0;
            X2        <= 1'b0;
            vec_idx   <= 2'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 4'd0;
            err_count <= 3'd0;
          end else begin
            state <= state;
          end
        end
        RUN: begin
          // Abort wins over a coincident end-of-window sample.
          if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            X1        <= 1'b0;
            X2        <= 1'b0;
            vec_idx   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 4'd0;
            err_count <= 3'd0;
            sample_z  <= 1'b0;
          end else if (cnt == LAST) begin
            sample_z     <= Z;
            sample_valid <= 1'b1;
            err_mask     <= mask_next;
            err_count    <= count_next;
            cnt          <= '0;
            if (vec_idx == 2'd3) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (mask_next == 4'd0);
              vec_idx <= 2'd0;
              X1      <= 1'b0;
              X2      <= 1'b0;
            end else begin
              vec_idx <= idx_next;
              X1      <= idx_next[1];
              X2      <= idx_next[0];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          X1    <= 1'b0;
          X2    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench: a HOLD_CYCLES=4 sequencer swept against several gate models,
// plus a HOLD_CYCLES=1 instance for the back-to-back restart case.
module tb_gate_tt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start4, abort4, start1, abort1;
  int   mode4, mode1;
  int   checks = 0;
  int   failures = 0;

  logic       z4, x1_4, x2_4, busy4, done4, pass4, sv4, sz4;
  logic [3:0] mask4;
  logic [2:0] cnt4;
  logic [1:0] idx4;
  logic       z1, x1_1, x2_1, busy1, done1, pass1, sv1, sz1;
  logic [3:0] mask1;
  logic [2:0] cnt1;
  logic [1:0] idx1;

  // Gate models: 0 OR, 1 AND, 2 tied-1, 3 tied-0, 4 XOR, 5 NAND.
  function automatic logic gate_z(input int mode, input logic [1:0] v);
    case (mode)
      0: gate_z = v[1] | v[0];
      1: gate_z = v[1] & v[0];
      2: gate_z = 1'b1;
      3: gate_z = 1'b0;
      4: gate_z = v[1] ^ v[0];
      5: gate_z = ~(v[1] & v[0]);
      default: gate_z = 1'b0;
    endcase
  endfunction

  always_comb z4 = gate_z(mode4, {x1_4, x2_4});
  always_comb z1 = gate_z(mode1, {x1_1, x2_1});

  gate_tt_sequencer #(.HOLD_CYCLES(4), .EXP_TT(4'b1110)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .Z(z4),
    .X1(x1_4), .X2(x2_4), .busy(busy4), .done(done4), .pass(pass4),
    .err_mask(mask4), .err_count(cnt4), .vec_idx(idx4),
    .sample_valid(sv4), .sample_z(sz4)
  );

  gate_tt_sequencer #(.HOLD_CYCLES(1), .EXP_TT(4'b1110)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .Z(z1),
    .X1(x1_1), .X2(x2_1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(mask1), .err_count(cnt1), .vec_idx(idx1),
    .sample_valid(sv1), .sample_z(sz1)
  );

  typedef struct {
    int         mode;
    logic [3:0] mask;
    logic [2:0] cnt;
    logic       pass;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] snap4();
    return {x1_4, x2_4, idx4, busy4, done4, pass4, mask4, cnt4, sv4, sz4};
  endfunction

  function automatic logic [15:0] snap1();
    return {x1_1, x2_1, idx1, busy1, done1, pass1, mask1, cnt1, sv1, sz1};
  endfunction

  // Full sweep on the HOLD_CYCLES=4 instance with per-cycle sequence checks.
  task automatic run_sweep4(input int mode, input logic hold_start,
                            input logic [3:0] emask, input logic [2:0] ecnt, input logic epass);
    logic [1:0] v;
    mode4  = mode;
    start4 = 1'b1;
    step();
    if (!hold_start) start4 = 1'b0;
    check("start_state", {busy4, done4, pass4, mask4, cnt4, x1_4, x2_4}, {1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 2'b00});
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) begin
        v = 2'(k / 4);
        check("x_seq", {x1_4, x2_4, idx4}, {v, v});
        check("busy_run", {busy4, done4}, 2'b10);
      end else begin
        check("done_at_16", {busy4, done4, x1_4, x2_4, idx4}, {2'b01, 4'd0});
        check("result", {mask4, cnt4, pass4}, {emask, ecnt, epass});
      end
      check("sample_valid", sv4, (k % 4 == 0) ? 1'b1 : 1'b0);
      if (k % 4 == 0) begin
        v = 2'(k / 4 - 1);
        check("sample_z", sz4, gate_z(mode, v));
      end
    end
    start4 = 1'b0;
  endtask

  initial begin
    logic [3:0] m1;
    logic [2:0] c1;
    tbl[0] = '{0, 4'b0000, 3'd0, 1'b1};
    tbl[1] = '{1, 4'b0110, 3'd2, 1'b0};
    tbl[2] = '{2, 4'b0001, 3'd1, 1'b0};
    tbl[3] = '{3, 4'b1110, 3'd3, 1'b0};
    tbl[4] = '{4, 4'b1000, 3'd1, 1'b0};
    tbl[5] = '{5, 4'b1001, 3'd2, 1'b0};

    rst_n = 1'b0; start4 = 1'b0; abort4 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    mode4 = 0; mode1 = 4;
    step(); step();
    check("reset4", snap4(), 16'd0);
    check("reset1", snap1(), 16'd0);
    rst_n = 1'b1;
    step();
    check("idle4", snap4(), 16'd0);

    for (int i = 0; i < 6; i++) begin
      run_sweep4(tbl[i].mode, 1'b0, tbl[i].mask, tbl[i].cnt, tbl[i].pass);
      abort4 = 1'b1;
      step(); step();
      abort4 = 1'b0;
      check("done_hold", {done4, busy4, mask4, cnt4, pass4}, {2'b10, tbl[i].mask, tbl[i].cnt, tbl[i].pass});
    end

    // Reset while vector 2 is driven.
    mode4 = 0; start4 = 1'b1; step(); start4 = 1'b0;
    repeat (8) step();
    check("mid_idx2", {idx4, x1_4, x2_4}, {2'd2, 2'b10});
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("mid_reset", snap4(), 16'd0);
    step();
    check("after_reset_idle", snap4(), 16'd0);
    run_sweep4(0, 1'b0, 4'b0000, 3'd0, 1'b1);

    // start held high for the entire sweep must not restart it.
    run_sweep4(1, 1'b1, 4'b0110, 3'd2, 1'b0);

    // Abort on the sampling edge of vector 1 (tied-1: vector 0 already failed).
    mode4 = 2; start4 = 1'b1; step(); start4 = 1'b0;
    repeat (7) step();
    check("pre_abort", {idx4, mask4, sz4, sv4}, {2'd1, 4'b0001, 1'b1, 1'b0});
    abort4 = 1'b1; step(); abort4 = 1'b0;
    check("abort_reset", snap4(), 16'd0);
    repeat (3) step();
    check("abort_stays_idle", snap4(), 16'd0);

    // HOLD_CYCLES=1 with XOR gate, then restart from DONE.
    for (int r = 0; r < 2; r++) begin
      start1 = 1'b1; step(); start1 = 1'b0;
      check("h1_start", {busy1, done1, mask1, cnt1, x1_1, x2_1, pass1}, {2'b10, 4'd0, 3'd0, 2'b00, 1'b0});
      for (int k = 1; k <= 3; k++) begin
        step();
        check("h1_x_seq", {x1_1, x2_1, busy1, sv1}, {2'(k), 2'b11});
      end
      step();
      check("h1_done", {done1, busy1, sv1, x1_1, x2_1}, {3'b101, 2'b00});
      check("h1_result", {mask1, cnt1, pass1}, {4'b1000, 3'd1, 1'b0});
      if (r == 0) begin
        m1 = mask1; c1 = cnt1;
      end else begin
        check("h1_repeat", {mask1, cnt1}, {m1, c1});
      end
      step();
      check("h1_sv_clear", {sv1, done1}, 2'b01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Self-checking truth-table sequencer for a 2-input combinational gate (default: the 2-input OR gate, `port_or`).
- Upstream of the gate: drives the gate inputs X1/X2 through vectors 00, 01, 10, 11, holding each for a programmable number of cycles.
- Downstream of the gate: samples Z at the end of each hold window and compares it to an expected truth table.
- Reports per-vector mismatches, an error count and pass/done status. Replaces hand-written `#50` stimulus-and-`$display` benches with a synthesizable, clocked checker.

Parameters:
- HOLD_CYCLES, 50, clock cycles each input vector is held before Z is sampled; legal range >=1.
- EXP_TT, 4'b1110, expected Z per vector; bit i = expected Z for {X1,X2} = i (OR gate = 4'b1110).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- abort  input  1  synchronous abort of a running sweep.
- Z  input  1  gate output under test.
- X1  output  1  gate input 1 (MSB of vector index).
- X2  output  1  gate input 2 (LSB of vector index).
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level, held until next start, abort or reset.
- pass  output  1  valid when done=1; 1 means no mismatches.
- err_mask  output  4  bit i set if vector i mismatched.
- err_count  output  3  number of mismatching vectors, 0..4.
- vec_idx  output  2  index of vector currently driven.
- sample_valid  output  1  one-cycle pulse the cycle after each Z sample.
- sample_z  output  1  last sampled Z value.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - Reset values: state=IDLE; X1=X2=0, vec_idx=0, busy=0, done=0, pass=0, err_mask=0, err_count=0, sample_valid=0, sample_z=0, hold counter=0.
  - Reset has priority over all other inputs, including mid-sweep. A sweep interrupted by reset is lost and does not resume.
- All outputs are registered. X1/X2 are always {vec_idx[1], vec_idx[0]} while busy; they are 00 otherwise.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> RUN.
  - Same edge: vec_idx=0, X=00, counter=0, busy=1, err_mask=0, err_count=0, done=0, pass=0.
- RUN, each edge:
  - If counter < HOLD_CYCLES-1: counter++.
  - If counter == HOLD_CYCLES-1, that edge:
    - sample_z<=Z and sample_valid<=1 (pulse, cleared next edge).
    - If Z != EXP_TT[vec_idx]: err_mask[vec_idx]<=1 and err_count increments.
    - If vec_idx<3: vec_idx++, X updates to the next vector, counter=0.
    - If vec_idx==3: -> DONE, busy=0, done=1, pass=(final err_mask==0, including the vector-3 result), X=00, vec_idx=0.
- Timing:
  - Each vector is driven for exactly HOLD_CYCLES cycles.
  - done rises at the 4*HOLD_CYCLES-th edge after the start edge.
  - Z is sampled at the edge that ends each hold window, so gate settle time must be shorter than HOLD_CYCLES cycles.
- DONE:
  - Holds done, pass, err_mask and err_count stable.
  - start=1 -> RUN with the same initialisation as from IDLE (the clear and restart happen on one edge).
- Ignored inputs:
  - start during RUN is ignored.
  - abort in IDLE or DONE is ignored.
- abort=1 in RUN:
  - -> IDLE at that edge.
  - All outputs return to reset values, and no sample is taken that edge.
  - abort has priority over a coincident end-of-window sample.
- HOLD_CYCLES=1: a sample every cycle; vectors advance back-to-back; the sweep takes 4 cycles.
- Counter width: clog2(HOLD_CYCLES+1); it must not wrap within a window.

Test Plan:
- Correct OR gate attached, HOLD_CYCLES=4, start pulsed:
  - X1X2 = 00, 01, 10, 11, each for 4 cycles.
  - 4 sample_valid pulses.
  - done=1 16 edges after the start edge; pass=1, err_mask=0000, err_count=0.
- AND gate attached (Z=X1&X2), EXP_TT=4'b1110 -> err_mask=0110, err_count=2, pass=0, done=1.
- Z tied to 1 -> err_mask=0001, err_count=1, pass=0. Z tied to 0 -> err_mask=1110, err_count=3.
- rst_n=0 for one edge while vec_idx=2 -> next cycle all outputs at reset values, state IDLE. A later start performs a full fresh sweep.
- Ignored and prioritised controls:
  - start held high throughout RUN -> no restart, done at cycle 16.
  - abort asserted on the exact sampling edge of vector 1 -> IDLE, sample_valid stays 0, err_mask=0000.
- HOLD_CYCLES=1, faulty gate, then start pulsed in DONE:
  - done after 4 cycles.
  - Restart clears err_mask, err_count and done on the same edge; the second sweep gives identical results.
